// File: rtl/uart_tx_framer_if.sv
// Host payload stream and TX FIFO push port of the UART TX framer.
// The host drives the request/payload side; the framer drives the FIFO push side.
interface uart_tx_framer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  start_i;
    logic [7:0]            len_i;
    logic [DATA_WIDTH-1:0] pl_data_i;
    logic                  pl_valid_i;
    logic                  pl_ready_o;
    logic                  tx_full_i;
    logic [DATA_WIDTH-1:0] tx_data_o;
    logic                  tx_wr_en_o;

    modport master (
        output start_i, len_i, pl_data_i, pl_valid_i, tx_full_i,
        input  pl_ready_o, tx_data_o, tx_wr_en_o
    );

    modport slave (
        input  start_i, len_i, pl_data_i, pl_valid_i, tx_full_i,
        output pl_ready_o, tx_data_o, tx_wr_en_o
    );
endinterface

// File: rtl/uart_tx_framer.sv
// Wraps a payload as SOF, LEN, payload, CHK and pushes it into the TX FIFO, one byte per cycle from the cycle after start.
// A full FIFO stalls every send state in place; payload is pulled only when a push can happen in the same cycle.
module uart_tx_framer #(
    parameter int         DATA_WIDTH = 8,
    parameter int         MAX_LEN    = 16,
    parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
    input  logic             baud_clk,
    input  logic             reset,
    uart_tx_framer_if.slave  bus,
    output logic             busy_o,
    output logic             done_o,
    output logic             len_error_o
);
    typedef enum logic [2:0] {
        IDLE,
        SEND_SOF,
        SEND_LEN,
        SEND_PL,
        SEND_CHK,
        DONE
    } state_t;

    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] rem_q, rem_d;
    logic [7:0] acc_q, acc_d;
    logic       len_err_q, len_err_d;

    logic                  wr_en;
    logic                  pl_rdy;
    logic [DATA_WIDTH-1:0] tx_dat;
    logic                  len_ok;

    assign len_ok = (bus.len_i != 8'd0) && (bus.len_i <= MAX_LEN_B);

    always_ff @(posedge baud_clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            len_q     <= 8'd0;
            rem_q     <= 8'd0;
            acc_q     <= 8'd0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            acc_q     <= acc_d;
            len_err_q <= len_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rem_d     = rem_q;
        acc_d     = acc_q;
        len_err_d = 1'b0;
        wr_en     = 1'b0;
        pl_rdy    = 1'b0;
        tx_dat    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    if (len_ok) begin
                        len_d   = bus.len_i;
                        rem_d   = bus.len_i;
                        acc_d   = 8'd0;
                        state_d = SEND_SOF;
                    end else begin
                        len_err_d = 1'b1;
                    end
                end
            end
            SEND_SOF: begin
                if (!bus.tx_full_i) begin
                    wr_en   = 1'b1;
                    tx_dat  = DATA_WIDTH'(SOF_BYTE);
                    state_d = SEND_LEN;
                end
            end
            SEND_LEN: begin
                if (!bus.tx_full_i) begin
                    wr_en   = 1'b1;
                    tx_dat  = DATA_WIDTH'(len_q);
                    acc_d   = len_q;
                    state_d = SEND_PL;
                end
            end
            SEND_PL: begin
                pl_rdy = !bus.tx_full_i;
                if (bus.pl_valid_i && !bus.tx_full_i) begin
                    wr_en  = 1'b1;
                    tx_dat = bus.pl_data_i;
                    acc_d  = acc_q + 8'(bus.pl_data_i);
                    rem_d  = rem_q - 8'd1;
                    // rem_q counts bytes still owed including this one
                    if (rem_q == 8'd1) begin
                        state_d = SEND_CHK;
                    end
                end
            end
            SEND_CHK: begin
                if (!bus.tx_full_i) begin
                    wr_en   = 1'b1;
                    tx_dat  = DATA_WIDTH'(acc_q);
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tx_wr_en_o = wr_en;
    assign bus.tx_data_o  = tx_dat;
    assign bus.pl_ready_o = pl_rdy;
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);
    assign len_error_o    = len_err_q;
endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer: frame content, timing, backpressure, illegal lengths and reset.
module tb_uart_tx_framer;
    typedef logic [7:0] byte_q_t[$];

    logic baud_clk;
    logic reset;
    logic busy_o;
    logic done_o;
    logic len_error_o;

    uart_tx_framer_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_framer #(
        .DATA_WIDTH(8),
        .MAX_LEN   (16),
        .SOF_BYTE  (8'hA5)
    ) dut (
        .baud_clk   (baud_clk),
        .reset      (reset),
        .bus        (bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .len_error_o(len_error_o)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int full_push_cnt = 0;
    byte_q_t push_q;
    int push_cyc_q[$];
    byte_q_t pl_q;
    logic gap = 1'b0;
    logic xfer_pend = 1'b0;

    initial baud_clk = 1'b0;
    always #5 baud_clk = ~baud_clk;

    always @(posedge baud_clk) cyc++;

    // Observe pushes and handshakes mid-cycle, where everything is settled.
    always @(negedge baud_clk) begin
        xfer_pend = bus.pl_valid_i && bus.pl_ready_o;
        if (bus.tx_wr_en_o) begin
            push_q.push_back(bus.tx_data_o);
            push_cyc_q.push_back(cyc);
            if (bus.tx_full_i) full_push_cnt++;
        end
        if (done_o) done_cnt++;
    end

    // Payload source: presents the head of pl_q and retires it after each accepted transfer.
    always @(posedge baud_clk) begin
        #2;
        if (xfer_pend && pl_q.size() > 0) pl_q.delete(0);
        bus.pl_valid_i = (pl_q.size() > 0) && !gap;
        bus.pl_data_i  = (pl_q.size() > 0) ? pl_q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge baud_clk);
        #1;
    endtask

    task automatic start(input logic [7:0] l, output int c_s);
        bus.start_i = 1'b1;
        bus.len_i   = l;
        tick();
        bus.start_i = 1'b0;
        c_s = cyc;
    endtask

    task automatic wait_done(input string tag, output int dcyc);
        bit seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(negedge baud_clk);
            if (done_o) seen = 1'b1;
        end
        dcyc = cyc;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frame(input string tag, input byte_q_t exp);
        check({tag, "_count"}, 32'(push_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < push_q.size())
                check($sformatf("%s_b%0d", tag, i), 32'(push_q[i]), 32'(exp[i]));
        end
        push_q.delete();
        push_cyc_q.delete();
    endtask

    initial begin
        byte_q_t exp;
        int c_s;
        int dcyc;
        int d0;

        reset          = 1'b0;
        bus.start_i    = 1'b0;
        bus.len_i      = 8'd0;
        bus.tx_full_i  = 1'b0;
        bus.pl_valid_i = 1'b0;
        bus.pl_data_i  = 8'h00;

        // Reset state
        #3;
        check("rst_wr_en", 32'(bus.tx_wr_en_o), 32'd0);
        check("rst_data", 32'(bus.tx_data_o), 32'd0);
        check("rst_ready", 32'(bus.pl_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_len_err", 32'(len_error_o), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // 1: basic frame, timing of pushes, done and busy
        pl_q = '{8'h01, 8'h02, 8'h03};
        tick();
        d0 = done_cnt;
        start(8'd3, c_s);
        @(negedge baud_clk);
        check("t1_busy", 32'(busy_o), 32'd1);
        wait_done("t1", dcyc);
        check("t1_first_cyc", 32'(push_cyc_q[0]), 32'(c_s));
        check("t1_last_cyc", 32'(push_cyc_q[push_cyc_q.size()-1]), 32'(c_s + 5));
        check("t1_done_cyc", 32'(dcyc), 32'(c_s + 6));
        @(negedge baud_clk);
        check("t1_busy_low", 32'(busy_o), 32'd0);
        check("t1_done_low", 32'(done_o), 32'd0);
        check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
        exp = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
        check_frame("t1", exp);
        tick();

        // 2: checksum wraps to zero
        pl_q = '{8'hFF, 8'hFF};
        tick();
        start(8'd2, c_s);
        wait_done("t2", dcyc);
        tick();
        exp = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00};
        check_frame("t2", exp);

        // 3: backpressure in payload and checksum phases
        pl_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        tick();
        start(8'd4, c_s);
        tick();
        tick();
        tick();
        bus.tx_full_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge baud_clk);
            check($sformatf("t3_pl_wr_%0d", i), 32'(bus.tx_wr_en_o), 32'd0);
            check($sformatf("t3_pl_rdy_%0d", i), 32'(bus.pl_ready_o), 32'd0);
            check($sformatf("t3_pl_dat_%0d", i), 32'(bus.tx_data_o), 32'd0);
            tick();
        end
        bus.tx_full_i = 1'b0;
        tick();
        tick();
        tick();
        bus.tx_full_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge baud_clk);
            check($sformatf("t3_chk_wr_%0d", i), 32'(bus.tx_wr_en_o), 32'd0);
            check($sformatf("t3_chk_busy_%0d", i), 32'(busy_o), 32'd1);
            tick();
        end
        bus.tx_full_i = 1'b0;
        wait_done("t3", dcyc);
        tick();
        exp = '{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'hA4};
        check_frame("t3", exp);
        check("t3_full_push", 32'(full_push_cnt), 32'd0);

        // 4: illegal lengths
        start(8'd0, c_s);
        @(negedge baud_clk);
        check("t4_len0_err", 32'(len_error_o), 32'd1);
        check("t4_len0_busy", 32'(busy_o), 32'd0);
        tick();
        check("t4_len0_err_off", 32'(len_error_o), 32'd0);
        start(8'd17, c_s);
        @(negedge baud_clk);
        check("t4_len17_err", 32'(len_error_o), 32'd1);
        check("t4_len17_busy", 32'(busy_o), 32'd0);
        tick();
        check("t4_len17_err_off", 32'(len_error_o), 32'd0);
        tick();
        exp = {};
        check_frame("t4", exp);

        // 5: start while busy is ignored, valid gap stalls payload
        pl_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        tick();
        d0 = done_cnt;
        start(8'd5, c_s);
        bus.start_i = 1'b1;
        bus.len_i   = 8'd2;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        gap = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge baud_clk);
            check($sformatf("t5_gap_wr_%0d", i), 32'(bus.tx_wr_en_o), 32'd0);
            tick();
        end
        gap = 1'b0;
        wait_done("t5", dcyc);
        @(negedge baud_clk);
        @(negedge baud_clk);
        check("t5_busy_after", 32'(busy_o), 32'd0);
        check("t5_done_cnt", 32'(done_cnt - d0), 32'd1);
        tick();
        exp = '{8'hA5, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h14};
        check_frame("t5", exp);

        // 6: reset mid-frame, then a clean frame
        pl_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        tick();
        d0 = done_cnt;
        start(8'd6, c_s);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("t6_rst_wr", 32'(bus.tx_wr_en_o), 32'd0);
        check("t6_rst_data", 32'(bus.tx_data_o), 32'd0);
        check("t6_rst_busy", 32'(busy_o), 32'd0);
        check("t6_rst_rdy", 32'(bus.pl_ready_o), 32'd0);
        pl_q.delete();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("t6_no_done", 32'(done_cnt - d0), 32'd0);
        exp = '{8'hA5, 8'h06};
        check_frame("t6_abort", exp);
        pl_q = '{8'h7E};
        tick();
        start(8'd1, c_s);
        wait_done("t6b", dcyc);
        tick();
        exp = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        check_frame("t6b", exp);
        check("final_full_push", 32'(full_push_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Packet framer that sits directly upstream of the UART top-level TX FIFO. It accepts a payload length and a byte stream from the host logic. It wraps them into a frame of SOF, LEN, payload bytes, and CHK, then pushes the frame byte by byte into the TX FIFO. It runs in the baud_clk domain, the same clock as the FIFO push side, and never pushes while the FIFO reports full.

Parameters:
DATA_WIDTH, 8, byte width of payload and FIFO data.
MAX_LEN, 16, largest legal payload length in bytes (1..255).
SOF_BYTE, 8'hA5, start-of-frame marker byte.

Ports:
baud_clk  input  1  clock; same clock as the TX FIFO push side.
reset  input  1  asynchronous, active-low reset.
start_i  input  1  one-cycle request to begin a frame; sampled only in IDLE.
len_i  input  8  payload length; latched when start_i is accepted.
pl_data_i  input  DATA_WIDTH  payload byte.
pl_valid_i  input  1  pl_data_i is valid.
pl_ready_o  output  1  framer accepts pl_data_i this cycle.
tx_full_i  input  1  TX FIFO full flag.
tx_data_o  output  DATA_WIDTH  byte to the TX FIFO data input.
tx_wr_en_o  output  1  TX FIFO push strobe.
busy_o  output  1  a frame is in progress (state is not IDLE).
done_o  output  1  one-cycle pulse after the CHK byte is pushed.
len_error_o  output  1  one-cycle pulse when start_i carries an illegal length.

Behaviour:
- Frame format: SOF_BYTE, LEN, then LEN payload bytes, then CHK.
  - CHK = (LEN + sum of payload bytes) mod 256, truncated to 8 bits.
  - SOF is not included in CHK.
- FSM states: IDLE, SEND_SOF, SEND_LEN, SEND_PL, SEND_CHK, DONE.
- IDLE:
  - start_i=1 with 1 <= len_i <= MAX_LEN: latch len_i into len_q, load remaining counter with len_i, clear the checksum accumulator to 0, go to SEND_SOF.
  - start_i=1 with len_i=0 or len_i > MAX_LEN: stay in IDLE, pulse len_error_o (registered) the next cycle, push nothing.
- Push rule (combinational): in SEND_SOF, SEND_LEN and SEND_CHK, tx_wr_en_o = ~tx_full_i.
  - tx_data_o = SOF_BYTE, len_q, or chk_q respectively.
  - The state advances only on a cycle where tx_wr_en_o=1.
- SEND_LEN push: accumulator becomes len_q.
- SEND_PL:
  - pl_ready_o = ~tx_full_i.
  - tx_wr_en_o = pl_valid_i & ~tx_full_i.
  - tx_data_o = pl_data_i, a combinational pass-through.
  - On each transfer, the accumulator adds pl_data_i mod 256 and the remaining counter decrements.
  - When the counter reaches 1 and a transfer occurs, go to SEND_CHK.
- SEND_CHK push: go to DONE. DONE lasts one cycle with done_o=1, then returns to IDLE.
  - Back-to-back frames therefore have one idle cycle plus the start cycle between them.
- pl_ready_o=0 in every state other than SEND_PL. tx_wr_en_o=0 in IDLE and DONE. tx_data_o=0 when not pushing.
- start_i is ignored whenever busy_o=1. A start_i arriving in the DONE cycle is also ignored.
- tx_full_i=1 stalls in any send state with no push and no state change. No byte is ever pushed on a cycle where tx_full_i=1.
- Width rules:
  - The remaining counter is 8 bits.
  - The checksum accumulator is 8 bits and wraps silently.
  - Frame length is LEN+3 bytes.
- Throughput: with no backpressure and pl_valid_i held high, a frame of length N produces N+3 pushes on N+3 consecutive cycles starting the cycle after start_i.
- Reset (asynchronous, active-low, reset=0):
  - Values: state=IDLE; len_q, counter and accumulator = 0.
  - All outputs = 0: pl_ready_o, tx_wr_en_o, tx_data_o, busy_o, done_o, len_error_o.
  - Reset mid-frame abandons the frame: no CHK is sent and no done_o pulse is produced.
  - After reset releases, the first start_i is accepted normally.

Test Plan:
1. Basic frame: start_i with len_i=3, payload 01 02 03 valid continuously, tx_full_i=0.
   -> Pushes A5 03 01 02 03 09 on 6 consecutive cycles.
   -> done_o pulses on the cycle after the 09 push; busy_o falls the cycle after that.
2. Checksum wrap: len_i=2, payload FF FF.
   -> Pushes A5 02 FF FF 00, since (2+FF+FF) mod 256 = 00.
3. Backpressure: frame of len_i=4; hold tx_full_i=1 for 3 cycles during SEND_PL, and again during SEND_CHK.
   -> No tx_wr_en_o while full, pl_ready_o=0, payload byte held.
   -> Frame content identical to the unstalled case; exactly 7 pushes total.
4. Illegal length: start_i with len_i=0, then with len_i=17 (MAX_LEN=16).
   -> len_error_o pulses once for each request; busy_o stays 0; zero pushes.
5. Busy and gap handling: during a len_i=5 frame, assert start_i with len_i=2; also drop pl_valid_i for 2 cycles mid-payload.
   -> Second start ignored; no push during the valid gap; one frame of 8 bytes with correct CHK.
6. Reset mid-frame: assert reset=0 after the LEN byte of a len_i=6 frame.
   -> All outputs 0 immediately (asynchronous); no CHK and no done_o.
   -> A following start_i with len_i=1 and payload 7E produces A5 01 7E 7F.
